// File: rtl/gray_conv_arbiter_pkg.sv
// rtl/gray_conv_arbiter_pkg.sv - shared encodings for the gray conversion arbiter
package gray_conv_arbiter_pkg;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/gray_bin_core.sv
// rtl/gray_bin_core.sv - combinational binary<->gray converter
module gray_bin_core
    import gray_conv_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] in,
    input  logic         mode,
    output logic [N-1:0] out
);

    logic [N-1:0] b2g;
    logic [N-1:0] g2b;
    logic         acc;

    assign b2g = in ^ (in >> 1);

    // Gray to binary is a running XOR from the MSB downwards.
    always_comb begin
        g2b = '0;
        acc = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            acc    = acc ^ in[i];
            g2b[i] = acc;
        end
    end

    assign out = (mode == MODE_G2B) ? g2b : b2g;

endmodule

// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - two-requester round-robin gray/binary converter with one result register
module gray_conv_arbiter
    import gray_conv_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic             a_mode,
    input  logic [N-1:0]     a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic             b_mode,
    input  logic [N-1:0]     b_data,
    output logic             b_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [N-1:0]     rsp_data,
    output logic             rsp_src,
    output logic             rsp_mode,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic             rsp_valid_q, rsp_valid_d;
    logic [N-1:0]     rsp_data_q,  rsp_data_d;
    logic             rsp_src_q,   rsp_src_d;
    logic             rsp_mode_q,  rsp_mode_d;
    logic             last_src_q,  last_src_d;
    logic [CNT_W-1:0] a_count_q,   a_count_d;
    logic [CNT_W-1:0] b_count_q,   b_count_d;

    logic         load_en;
    logic         grant_a;
    logic         grant_b;
    logic         sel_mode;
    logic [N-1:0] sel_data;
    logic [N-1:0] conv_data;

    // Arbitration looks only at valids, the pointer and rsp_ready.
    always_comb begin
        load_en  = !rsp_valid_q || rsp_ready;
        grant_a  = a_valid && (!b_valid || (last_src_q == SRC_B));
        grant_b  = b_valid && !grant_a;
        a_ready  = load_en && grant_a;
        b_ready  = load_en && grant_b;
        sel_mode = grant_b ? b_mode : a_mode;
        sel_data = grant_b ? b_data : a_data;
    end

    gray_bin_core #(.N(N)) u_core (
        .in   (sel_data),
        .mode (sel_mode),
        .out  (conv_data)
    );

    // Drain and load are independent so both take effect in the same cycle.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_src_d   = rsp_src_q;
        rsp_mode_d  = rsp_mode_q;
        last_src_d  = last_src_q;
        a_count_d   = a_count_q;
        b_count_d   = b_count_q;
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
            if (rsp_src_q == SRC_B) begin
                b_count_d = b_count_q + CNT_W'(1);
            end else begin
                a_count_d = a_count_q + CNT_W'(1);
            end
        end
        if (a_ready || b_ready) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = conv_data;
            rsp_src_d   = b_ready ? SRC_B : SRC_A;
            rsp_mode_d  = sel_mode;
            last_src_d  = b_ready ? SRC_B : SRC_A;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_src_q   <= SRC_A;
            rsp_mode_q  <= MODE_B2G;
            last_src_q  <= SRC_B;
            a_count_q   <= '0;
            b_count_q   <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_src_q   <= rsp_src_d;
            rsp_mode_q  <= rsp_mode_d;
            last_src_q  <= last_src_d;
            a_count_q   <= a_count_d;
            b_count_q   <= b_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_src   = rsp_src_q;
    assign rsp_mode  = rsp_mode_q;
    assign a_count   = a_count_q;
    assign b_count   = b_count_q;

endmodule
